// File: rtl/reader_fifo_serializer.sv
// reader_fifo_serializer: pops 32-bit reader-FIFO words and streams them one byte per cycle with lane index.
// Define SERIALIZER_MSB_FIRST_EN to present lanes 3..0 within each word instead of 0..3.
module reader_fifo_serializer #(
  parameter int LEN_WIDTH  = 6,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  i_start,
  input  logic [LEN_WIDTH-1:0]  i_length,
  input  logic                  i_fifo_empty,
  input  logic [DATA_WIDTH-1:0] i_fifo_dout,
  output logic                  o_fifo_rd_en,
  output logic [7:0]            o_serialized_output,
  output logic                  o_serialized_output_valid,
  output logic [1:0]            o_serialize_counter,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_underflow
);
  typedef enum logic [2:0] {IDLE, REQ, LOAD, STREAM, DONE} state_t;
  state_t state, state_n;
  logic [LEN_WIDTH-2:0] words_left;
  logic [1:0] tail, lane, end_lane;
  logic [DATA_WIDTH-1:0] word;
  logic cur_last, pf, at_end, reload;
`ifdef SERIALIZER_MSB_FIRST_EN
  localparam logic [1:0] FIRST = 2'd3, PF_LANE = 2'd1, FULL_END = 2'd0, STEP = 2'd3;
  assign end_lane = 2'd0 - tail;
`else
  localparam logic [1:0] FIRST = 2'd0, PF_LANE = 2'd2, FULL_END = 2'd3, STEP = 2'd1;
  assign end_lane = tail - 2'd1;
`endif
  // pf holds whether the prefetch issued on the lane just before the word's final lane
  assign at_end = state == STREAM && lane == (cur_last ? end_lane : FULL_END);
  assign reload = at_end && !cur_last && pf;
  always_ff @(posedge CLK) state <= RESET ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:    state_n = i_start ? (i_length == '0 ? DONE : REQ) : IDLE;
      REQ:     state_n = o_fifo_rd_en ? LOAD : REQ;
      LOAD:    state_n = STREAM;
      STREAM:  state_n = !at_end ? STREAM : cur_last ? DONE : pf ? STREAM : REQ;
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    o_fifo_rd_en = !i_fifo_empty && (state == REQ || (state == STREAM && lane == PF_LANE && words_left != '0));
    o_serialized_output_valid = state == STREAM;
    o_serialized_output = state == STREAM ? word[8*lane +: 8] : 8'd0;
    o_serialize_counter = state == STREAM ? lane : 2'd0;
    o_busy = state == REQ || state == LOAD || state == STREAM;
    o_done = state == DONE;
  end
  always_ff @(posedge CLK) begin
    if (RESET) begin
      words_left  <= '0;
      tail        <= '0;
      lane        <= '0;
      word        <= '0;
      cur_last    <= 1'b0;
      pf          <= 1'b0;
      o_underflow <= 1'b0;
    end else begin
      pf <= o_fifo_rd_en;
      if (state == IDLE && i_start) begin
        words_left  <= {1'b0, i_length[LEN_WIDTH-1:2]} + (LEN_WIDTH-1)'(|i_length[1:0]);
        tail        <= i_length[1:0];
        o_underflow <= 1'b0;
      end else if (o_fifo_rd_en) words_left <= words_left - (LEN_WIDTH-1)'(1);
      if (state == LOAD || reload) begin
        word     <= i_fifo_dout;
        lane     <= FIRST;
        cur_last <= words_left == '0;
      end else if (state == STREAM) lane <= lane + STEP;
      if (at_end && !cur_last && !pf) o_underflow <= 1'b1;
    end
  end
endmodule
